// File: rtl/ctr_stream_ctrl_if.sv
// Block-stream and CTR-core handshake bundle for ctr_stream_ctrl.
// master = controller side, slave = environment (stream source/sink plus core).
interface ctr_stream_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         core_init;
    logic         core_next;
    logic [127:0] core_data;
    logic         core_ready;
    logic [127:0] core_out;

    modport master (
        input  in_valid, in_data, out_ready, core_ready, core_out,
        output in_ready, out_valid, out_data, core_init, core_next, core_data
    );

    modport slave (
        output in_valid, in_data, out_ready, core_ready, core_out,
        input  in_ready, out_valid, out_data, core_init, core_next, core_data
    );
endinterface

// File: rtl/ctr_stream_ctrl.sv
// Sequences key expansion and one-block-at-a-time CTR-core processing between two stream handshakes.
// Latency: accept -> ISSUE -> WAIT_LO -> WAIT_HI (core time) -> OUT; at least 3 cycles plus core compute.
// Backpressure: in_ready only in READY with no key_load; OUT holds out_valid/out_data until out_ready.
module ctr_stream_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     key_load_i,
    ctr_stream_ctrl_if.master        bus,
    output logic                     key_valid_o,
    output logic                     err_timeout_o,
    output logic [31:0]              block_count_o
);

    typedef enum logic [3:0] {
        NOKEY, KINIT, KWAIT_LO, KWAIT_HI, READY, ISSUE, WAIT_LO, WAIT_HI, OUT
    } state_e;

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [127:0] core_data_q, core_data_d;
    logic [127:0] out_data_q, out_data_d;
    logic         key_valid_q, key_valid_d;
    logic         err_q, err_d;
    logic [31:0]  count_q, count_d;
    logic [15:0]  wdog_q, wdog_d;
    logic         wdog_expired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= NOKEY;
            core_data_q <= '0;
            out_data_q  <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            core_data_q <= core_data_d;
            out_data_q  <= out_data_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            count_q     <= count_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        core_data_d  = core_data_q;
        out_data_d   = out_data_q;
        key_valid_d  = key_valid_q;
        err_d        = err_q;
        count_d      = count_q;
        wdog_d       = '0;
        wdog_expired = (wdog_q == WDOG_LIMIT);

        case (state_q)
            NOKEY: begin
                if (key_load_i) state_d = KINIT;
            end
            KINIT: state_d = KWAIT_LO;
            KWAIT_LO: begin
                wdog_d = wdog_q + 16'd1;
                if (!bus.core_ready) state_d = KWAIT_HI;
                else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = NOKEY;
                end
            end
            KWAIT_HI: begin
                wdog_d = wdog_q + 16'd1;
                if (bus.core_ready) begin
                    key_valid_d = 1'b1;
                    state_d     = READY;
                end else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = NOKEY;
                end
            end
            READY: begin
                // A re-key request wins over a block offered in the same cycle.
                if (key_load_i) begin
                    key_valid_d = 1'b0;
                    state_d     = KINIT;
                end else if (bus.in_valid) begin
                    core_data_d = bus.in_data;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_LO;
            WAIT_LO: begin
                wdog_d = wdog_q + 16'd1;
                if (!bus.core_ready) state_d = WAIT_HI;
                else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = NOKEY;
                end
            end
            WAIT_HI: begin
                wdog_d = wdog_q + 16'd1;
                if (bus.core_ready) begin
                    out_data_d = bus.core_out;
                    state_d    = OUT;
                end else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = NOKEY;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    count_d = count_q + 32'd1;
                    state_d = READY;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    assign bus.in_ready   = (state_q == READY) && !key_load_i;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_data   = out_data_q;
    assign bus.core_init  = (state_q == KINIT);
    assign bus.core_next  = (state_q == ISSUE);
    assign bus.core_data  = core_data_q;
    assign key_valid_o    = key_valid_q;
    assign err_timeout_o  = err_q;
    assign block_count_o  = count_q;

endmodule

// File: tb/tb_ctr_stream_ctrl.sv
// Directed bench for ctr_stream_ctrl with a behavioural CTR core and an expected-result queue.
module tb_ctr_stream_ctrl;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic        clk_i;
    logic        rst_ni;
    logic        key_load_i;
    logic        key_valid_o;
    logic        err_timeout_o;
    logic [31:0] block_count_o;

    ctr_stream_ctrl_if ifc ();

    ctr_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .key_load_i    (key_load_i),
        .bus           (ifc),
        .key_valid_o   (key_valid_o),
        .err_timeout_o (err_timeout_o),
        .block_count_o (block_count_o)
    );

    int nvec  = 0;
    int nfail = 0;
    int n_init = 0;
    int n_next = 0;
    int n_outv = 0;
    int busy   = 0;
    bit hang   = 1'b0;
    logic [127:0] sb[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Core model: result is a pure XOR with the key; ready drops after a request.
    assign ifc.core_out = ifc.core_data ^ KEY;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ifc.core_ready = 1'b1;
        forever begin
            @(negedge clk_i);
            if ((ifc.core_init || ifc.core_next) && !hang) busy = 11;
            else if (busy > 0) busy--;
            ifc.core_ready = (busy == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (ifc.core_init) n_init++;
                if (ifc.core_next) n_next++;
                if (ifc.out_valid) n_outv++;
                if (ifc.core_init || ifc.core_next)
                    check("init_next_excl", {127'd0, ifc.core_init & ifc.core_next}, 128'd0);
            end
        end
    end

    task automatic load_key();
        @(negedge clk_i);
        key_load_i = 1'b1;
        @(negedge clk_i);
        key_load_i = 1'b0;
    endtask

    task automatic wait_key();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            ok = key_valid_o;
        end
        check("key_valid_wait", {127'd0, ok}, 128'd1);
    endtask

    task automatic send_block(input logic [127:0] d);
        bit done = 1'b0;
        @(negedge clk_i);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (ifc.in_ready) begin
                sb.push_back(d ^ KEY);
                done = 1'b1;
            end
            @(negedge clk_i);
        end
        ifc.in_valid = 1'b0;
        check("in_accept", {127'd0, done}, 128'd1);
    endtask

    task automatic recv_block(input int stall);
        bit seen = 1'b0;
        logic [127:0] exp;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            seen = ifc.out_valid;
        end
        check("out_valid_seen", {127'd0, seen}, 128'd1);
        check("sb_nonempty", {127'd0, sb.size() > 0}, 128'd1);
        if (seen && sb.size() > 0) begin
            exp = sb.pop_front();
            check("out_data", ifc.out_data, exp);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk_i);
                check("out_hold_vld", {127'd0, ifc.out_valid}, 128'd1);
                check("out_hold_dat", ifc.out_data, exp);
            end
            ifc.out_ready = 1'b1;
            @(negedge clk_i);
            ifc.out_ready = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {127'd0, ifc.in_ready},  128'd0);
        check({tag, "_out_valid"}, {127'd0, ifc.out_valid}, 128'd0);
        check({tag, "_out_data"},  ifc.out_data,  128'd0);
        check({tag, "_core_data"}, ifc.core_data, 128'd0);
        check({tag, "_core_init"}, {127'd0, ifc.core_init}, 128'd0);
        check({tag, "_core_next"}, {127'd0, ifc.core_next}, 128'd0);
        check({tag, "_key_valid"}, {127'd0, key_valid_o},   128'd0);
        check({tag, "_err"},       {127'd0, err_timeout_o}, 128'd0);
        check({tag, "_count"},     {96'd0, block_count_o},  128'd0);
    endtask

    initial begin
        int n_init0, n_next0, n_outv0;
        bit got;
        logic [127:0] d;

        rst_ni        = 1'b1;
        key_load_i    = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Key expansion
        load_key();
        wait_key();
        #1;
        check("key_init_pulses", n_init, 1);
        check("key_in_ready", {127'd0, ifc.in_ready}, 128'd1);

        // First block with stalled sink
        send_block(128'h00112233445566778899AABBCCDDEEFF);
        recv_block(5);
        check("next_pulses_1", n_next, 1);
        check("count_1", {96'd0, block_count_o}, 128'd1);

        // A few more blocks with varied data
        for (int k = 0; k < 3; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send_block(d);
            recv_block(k);
        end
        check("count_4", {96'd0, block_count_o}, 128'd4);
        check("next_pulses_4", n_next, 4);

        // Re-key collides with an offered block
        n_init0 = n_init;
        n_next0 = n_next;
        @(negedge clk_i);
        key_load_i   = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        #1 check("collide_in_ready", {127'd0, ifc.in_ready}, 128'd0);
        @(negedge clk_i);
        key_load_i   = 1'b0;
        ifc.in_valid = 1'b0;
        check("collide_key_cleared", {127'd0, key_valid_o}, 128'd0);
        wait_key();
        check("collide_init_pulse", n_init, n_init0 + 1);
        check("collide_no_next", n_next, n_next0);
        check("collide_count", {96'd0, block_count_o}, 128'd4);

        // Counter wrap from all-ones
        @(negedge clk_i);
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        send_block(128'h0F0E0D0C0B0A09080706050403020100);
        recv_block(0);
        check("count_wrap", {96'd0, block_count_o}, 128'd0);

        // Watchdog: core never drops ready after core_next
        hang    = 1'b1;
        n_outv0 = n_outv;
        send_block(128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D);
        void'(sb.pop_back());
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ifc.core_next) got = 1'b1;
            else @(negedge clk_i);
        end
        check("to_issue_seen", {127'd0, got}, 128'd1);
        repeat (TIMEOUT - 4) @(negedge clk_i);
        check("to_not_early", {127'd0, err_timeout_o}, 128'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            got = err_timeout_o;
        end
        check("to_err", {127'd0, got}, 128'd1);
        check("to_key_valid", {127'd0, key_valid_o}, 128'd0);
        #1 check("to_in_ready", {127'd0, ifc.in_ready}, 128'd0);
        repeat (5) @(negedge clk_i);
        check("to_no_out_valid", n_outv, n_outv0);
        hang = 1'b0;
        n_init0 = n_init;
        load_key();
        wait_key();
        check("to_rekey_pulse", n_init, n_init0 + 1);
        check("to_err_sticky", {127'd0, err_timeout_o}, 128'd1);

        // Reset while waiting for the core result
        send_block(128'h55AA55AA_55AA55AA_55AA55AA_55AA55AA);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ifc.core_next) got = 1'b1;
            else @(negedge clk_i);
        end
        check("rst_issue_seen", {127'd0, got}, 128'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("post_rst_in_ready", {127'd0, ifc.in_ready}, 128'd0);
        check("post_rst_key_valid", {127'd0, key_valid_o}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
